// File: rtl/nts_dispatch_fifo.sv
// nts_dispatch_fifo: two-slot packet FIFO between the receive MAC path and nts_rx_buffer.
// Complete good frames are committed into a slot and offered one at a time in arrival order;
// errored, oversize and no-space frames are discarded whole and counted.
module nts_dispatch_fifo #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_rx_valid,
  input  logic [63:0] i_rx_data,
  input  logic        i_rx_last,
  input  logic        i_rx_bad,
  output logic        o_dispatch_packet_available,
  input  logic        i_dispatch_packet_read,
  output logic        o_dispatch_fifo_empty,
  input  logic        i_dispatch_fifo_rd_start,
  output logic        o_dispatch_fifo_rd_valid,
  output logic [63:0] o_dispatch_fifo_rd_data,
  output logic [31:0] o_dropped_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] W_IDLE     = 2'd0;
  localparam logic [1:0] W_FILL     = 2'd1;
  localparam logic [1:0] W_DISCARD  = 2'd2;

  localparam logic [1:0] R_IDLE     = 2'd0;
  localparam logic [1:0] R_OFFER    = 2'd1;
  localparam logic [1:0] R_STREAM   = 2'd2;
  localparam logic [1:0] R_WAIT_ACK = 2'd3;

  logic [63:0]         mem [0:2*DEPTH-1];
  logic [CW-1:0]       slot_cnt [0:1];
  logic [1:0]          slot_full;

  // arrival-order queue of committed slots; q0 is the slot the reader serves
  logic                q0, q1;
  logic [1:0]          qn;

  logic [1:0]          w_state, w_state_nx;
  logic                w_slot, w_slot_nx;
  logic [CW-1:0]       w_cnt, w_cnt_nx;
  logic                wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                commit, drop;
  logic [CW-1:0]       commit_cnt;
  logic [31:0]         dropped;

  logic [1:0]          r_state;
  logic                rd_slot;
  logic [CW-1:0]       rd_idx;
  logic                rd_en_p0;
  logic                pop;
  logic                vld_p1;
  logic [63:0]         rd_data_p1;

  assign pop      = (r_state == R_WAIT_ACK) && i_dispatch_packet_read;
  assign rd_en_p0 = (r_state == R_STREAM) && (rd_idx != slot_cnt[rd_slot]);

  assign o_dispatch_packet_available = (r_state != R_IDLE);
  assign o_dispatch_fifo_empty       = (r_state == R_IDLE) || (r_state == R_WAIT_ACK);
  assign o_dispatch_fifo_rd_valid    = vld_p1;
  assign o_dispatch_fifo_rd_data     = rd_data_p1;
  assign o_dropped_count             = dropped;

  // write-side decode: where the incoming word goes and whether the frame commits or drops
  always_comb begin
    w_state_nx = w_state;
    w_slot_nx  = w_slot;
    w_cnt_nx   = w_cnt;
    wr_en      = 1'b0;
    wr_idx     = w_cnt[ADDR_WIDTH-1:0];
    commit     = 1'b0;
    drop       = 1'b0;
    commit_cnt = w_cnt + CW'(1);
    if (i_rx_valid) begin
      case (w_state)
        W_IDLE: begin
          wr_idx     = '0;
          commit_cnt = CW'(1);
          if (!slot_full[0] || !slot_full[1]) begin
            // lower-numbered free slot: slot 1 only when slot 0 is occupied
            w_slot_nx = slot_full[0];
            wr_en     = 1'b1;
            w_cnt_nx  = CW'(1);
            if (i_rx_last) begin
              commit = !i_rx_bad;
              drop   = i_rx_bad;
            end else begin
              w_state_nx = W_FILL;
            end
          end else if (i_rx_last) begin
            drop = 1'b1;
          end else begin
            w_state_nx = W_DISCARD;
          end
        end
        W_FILL: begin
          if (w_cnt == FULL_CNT) begin
            // one word past a full slot: the frame is oversize
            if (i_rx_last) begin
              drop       = 1'b1;
              w_state_nx = W_IDLE;
            end else begin
              w_state_nx = W_DISCARD;
            end
          end else begin
            wr_en    = 1'b1;
            w_cnt_nx = w_cnt + CW'(1);
            if (i_rx_last) begin
              commit     = !i_rx_bad;
              drop       = i_rx_bad;
              w_state_nx = W_IDLE;
            end
          end
        end
        W_DISCARD: begin
          if (i_rx_last) begin
            drop       = 1'b1;
            w_state_nx = W_IDLE;
          end
        end
        default: w_state_nx = W_IDLE;
      endcase
    end
  end

  // control state: write FSM, slot occupancy, arrival queue, drop counter and read FSM
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      w_state   <= W_IDLE;
      w_slot    <= 1'b0;
      w_cnt     <= '0;
      slot_full <= 2'b00;
      q0        <= 1'b0;
      q1        <= 1'b0;
      qn        <= 2'd0;
      dropped   <= '0;
      r_state   <= R_IDLE;
      rd_slot   <= 1'b0;
      rd_idx    <= '0;
      vld_p1    <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      w_slot  <= w_slot_nx;
      w_cnt   <= w_cnt_nx;
      if (drop) dropped <= dropped + 32'd1;

      if (commit) slot_full[w_slot_nx] <= 1'b1;
      if (pop)    slot_full[rd_slot]   <= 1'b0;

      if (commit && pop) begin
        if (qn == 2'd2) begin
          q0 <= q1;
          q1 <= w_slot_nx;
        end else begin
          q0 <= w_slot_nx;
        end
      end else if (commit) begin
        if (qn == 2'd0) q0 <= w_slot_nx;
        else            q1 <= w_slot_nx;
        qn <= qn + 2'd1;
      end else if (pop) begin
        q0 <= q1;
        qn <= qn - 2'd1;
      end

      case (r_state)
        R_IDLE: begin
          if (qn != 2'd0) begin
            r_state <= R_OFFER;
            rd_slot <= q0;
          end
        end
        R_OFFER: begin
          if (i_dispatch_fifo_rd_start) begin
            r_state <= R_STREAM;
            rd_idx  <= '0;
          end
        end
        R_STREAM: begin
          if (rd_idx == slot_cnt[rd_slot]) r_state <= R_WAIT_ACK;
          else                             rd_idx  <= rd_idx + CW'(1);
        end
        R_WAIT_ACK: begin
          if (i_dispatch_packet_read) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase

      // read stage p0 -> p1: valid follows the registered RAM read
      vld_p1 <= rd_en_p0;
    end
  end

  // packet RAM write port and per-slot word count capture
  always_ff @(posedge i_clk) begin
    if (wr_en)  mem[{w_slot_nx, wr_idx}] <= i_rx_data;
    if (commit) slot_cnt[w_slot_nx]      <= commit_cnt;
  end

  // registered RAM read; data holds while no read is issued
  always_ff @(posedge i_clk) begin
    if (i_areset)      rd_data_p1 <= '0;
    else if (rd_en_p0) rd_data_p1 <= mem[{rd_slot, rd_idx[ADDR_WIDTH-1:0]}];
  end

endmodule
